// File: rtl/rr_priority_arbiter.sv
// Request arbiter with a registered grant and a valid/ready handshake.
// ROUND_ROBIN=1 rotates priority starting at the slot after the last winner.
// ROUND_ROBIN=0 always picks the highest-numbered active request.
// The grant is held stable until the consumer accepts it. On acceptance the
// block re-arbitrates in the same cycle, so grants issue back to back.
module rr_priority_arbiter #(
  parameter int OUTPUT_WIDTH = 3,
  parameter int INPUT_WIDTH  = 1 << OUTPUT_WIDTH,
  parameter int ROUND_ROBIN  = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [INPUT_WIDTH-1:0]  input_data,
  input  logic                    output_ready,
  output logic                    output_valid,
  output logic [OUTPUT_WIDTH-1:0] output_data,
  output logic [INPUT_WIDTH-1:0]  output_onehot
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [OUTPUT_WIDTH-1:0] LAST_IDX = OUTPUT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [OUTPUT_WIDTH-1:0] IDX_ONE  = OUTPUT_WIDTH'(1);

  state_t                  r_state;
  logic [OUTPUT_WIDTH-1:0] r_ptr;
  logic                    r_valid;
  logic [OUTPUT_WIDTH-1:0] r_data;
  logic [INPUT_WIDTH-1:0]  r_onehot;

  logic                    w_any;
  logic                    w_upper_hit;
  logic [OUTPUT_WIDTH-1:0] w_upper_idx;
  logic [OUTPUT_WIDTH-1:0] w_lower_idx;
  logic [OUTPUT_WIDTH-1:0] w_high_idx;
  logic [OUTPUT_WIDTH-1:0] w_win_idx;
  logic [INPUT_WIDTH-1:0]  w_win_onehot;
  logic [OUTPUT_WIDTH-1:0] w_next_ptr;
  logic                    w_load;

  assign w_any = |input_data;

  // Scan the request vector for the three candidate winners.
  // Candidates: lowest index at or above ptr, lowest overall, and highest overall.
  always_comb begin
    w_upper_hit = 1'b0;
    w_upper_idx = '0;
    w_lower_idx = '0;
    w_high_idx  = '0;
    // A downward scan leaves the lowest matching index in the variable.
    for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
      if (input_data[i]) begin
        w_lower_idx = OUTPUT_WIDTH'(i);
        if (i >= int'(r_ptr)) begin
          w_upper_hit = 1'b1;
          w_upper_idx = OUTPUT_WIDTH'(i);
        end
      end
    end
    // An upward scan leaves the highest matching index in the variable.
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (input_data[i]) begin
        w_high_idx = OUTPUT_WIDTH'(i);
      end
    end
  end

  // Choose the winner for the current mode, and build its one-hot code and the next pointer.
  always_comb begin
    if (ROUND_ROBIN != 0) begin
      // Use the first request at or above ptr; otherwise wrap to the lowest request.
      w_win_idx = w_upper_hit ? w_upper_idx : w_lower_idx;
    end else begin
      w_win_idx = w_high_idx;
    end
    w_win_onehot = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (OUTPUT_WIDTH'(i) == w_win_idx) begin
        w_win_onehot[i] = 1'b1;
      end
    end
    // The pointer moves past the winner and wraps at the last real requester.
    // It does not wrap at the power of two.
    w_next_ptr = (w_win_idx == LAST_IDX) ? '0 : (w_win_idx + IDX_ONE);
  end

  // A new grant is loaded from IDLE, or when the consumer accepts the current grant.
  // Either way, at least one request must be present.
  assign w_load = w_any && ((r_state == ST_IDLE) || output_ready);

  // Grant state machine. Every output is registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state  <= ST_GRANT;
            r_valid  <= 1'b1;
            r_data   <= w_win_idx;
            r_onehot <= w_win_onehot;
            r_ptr    <= w_next_ptr;
          end
        end
        ST_GRANT: begin
          if (output_ready) begin
            if (w_load) begin
              r_valid  <= 1'b1;
              r_data   <= w_win_idx;
              r_onehot <= w_win_onehot;
              r_ptr    <= w_next_ptr;
            end else begin
              // The grant was accepted and nobody is waiting, so drop to IDLE.
              // output_data keeps the last index.
              r_state  <= ST_IDLE;
              r_valid  <= 1'b0;
              r_onehot <= '0;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_valid  <= 1'b0;
          r_onehot <= '0;
        end
      endcase
    end
  end

  assign output_valid  = r_valid;
  assign output_data   = r_data;
  assign output_onehot = r_onehot;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter.
// It runs one round-robin instance and one fixed-priority instance, both 8 requesters wide.
// The stimulus queues the hand-computed grants it expects.
// A negedge monitor compares every presented grant against the head of the queue.
// It pops the head on a handshake.
module tb_rr_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] input_data = 8'h00;
  logic       output_ready = 1'b0;

  logic       rr_valid;
  logic [2:0] rr_data;
  logic [7:0] rr_oh;
  logic       fx_valid;
  logic [2:0] fx_data;
  logic [7:0] fx_oh;

  typedef struct packed {
    logic [2:0] d;
    logic [7:0] oh;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fx[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_rr_en = 1'b0;
  logic mon_fx_en = 1'b0;

  rr_priority_arbiter #(.OUTPUT_WIDTH(3), .INPUT_WIDTH(8), .ROUND_ROBIN(1)) dut_rr (
    .CLK          (CLK),
    .RST          (RST),
    .input_data   (input_data),
    .output_ready (output_ready),
    .output_valid (rr_valid),
    .output_data  (rr_data),
    .output_onehot(rr_oh)
  );

  rr_priority_arbiter #(.OUTPUT_WIDTH(3), .INPUT_WIDTH(8), .ROUND_ROBIN(0)) dut_fx (
    .CLK          (CLK),
    .RST          (RST),
    .input_data   (input_data),
    .output_ready (output_ready),
    .output_valid (fx_valid),
    .output_data  (fx_data),
    .output_onehot(fx_oh)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_rr(input logic [2:0] d, input logic [7:0] oh);
    exp_t e;
    e.d  = d;
    e.oh = oh;
    q_rr.push_back(e);
  endtask

  task automatic push_fx(input logic [2:0] d, input logic [7:0] oh);
    exp_t e;
    e.d  = d;
    e.oh = oh;
    q_fx.push_back(e);
  endtask

  // Monitor: check each presented grant against the queue head, and check idle outputs.
  always @(negedge CLK) begin
    if (mon_rr_en) begin
      if (rr_valid) begin
        if (q_rr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rr_unexpected_grant: got data %0d onehot %0h, expected no grant", rr_data, rr_oh);
        end else begin
          chk("rr_data", {29'd0, rr_data}, {29'd0, q_rr[0].d});
          chk("rr_onehot", {24'd0, rr_oh}, {24'd0, q_rr[0].oh});
          if (output_ready) void'(q_rr.pop_front());
        end
      end else begin
        chk("rr_idle_onehot", {24'd0, rr_oh}, 32'd0);
      end
    end
    if (mon_fx_en) begin
      if (fx_valid) begin
        if (q_fx.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL fx_unexpected_grant: got data %0d onehot %0h, expected no grant", fx_data, fx_oh);
        end else begin
          chk("fx_data", {29'd0, fx_data}, {29'd0, q_fx[0].d});
          chk("fx_onehot", {24'd0, fx_oh}, {24'd0, q_fx[0].oh});
          if (output_ready) void'(q_fx.pop_front());
        end
      end else begin
        chk("fx_idle_onehot", {24'd0, fx_oh}, 32'd0);
      end
    end
  end

  // Watchdog: stop the run if it overruns its time budget.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    // Reset, then check the outputs while requests stay idle.
    RST = 1'b1; input_data = 8'h00; output_ready = 1'b0;
    step(); step();
    chk("rst_valid", {31'd0, rr_valid}, 32'd0);
    chk("rst_onehot", {24'd0, rr_oh}, 32'd0);
    chk("rst_data", {29'd0, rr_data}, 32'd0);
    chk("rst_fx_valid", {31'd0, fx_valid}, 32'd0);
    RST = 1'b0;
    mon_rr_en = 1'b1;
    repeat (5) begin
      step();
      chk("idle_valid", {31'd0, rr_valid}, 32'd0);
      chk("idle_onehot", {24'd0, rr_oh}, 32'd0);
    end

    // Requests 0x84 held with ready high should grant 2,7,2,7 back to back.
    input_data = 8'h84; output_ready = 1'b1;
    push_rr(3'd2, 8'h04); push_rr(3'd7, 8'h80); push_rr(3'd2, 8'h04); push_rr(3'd7, 8'h80);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("b2b_valid", {31'd0, rr_valid}, 32'd1);
    end
    input_data = 8'h00;
    step();
    chk("drain_valid", {31'd0, rr_valid}, 32'd0);
    chk("drain_onehot", {24'd0, rr_oh}, 32'd0);
    chk("idle_keeps_data", {29'd0, rr_data}, 32'd7);

    // The pointer has wrapped to 0, so requests 0x81 grant 0 and then 7.
    input_data = 8'h81;
    push_rr(3'd0, 8'h01); push_rr(3'd7, 8'h80);
    step();
    chk("wrap_first_valid", {31'd0, rr_valid}, 32'd1);
    step();
    input_data = 8'h00;
    step();
    chk("wrap_drain_valid", {31'd0, rr_valid}, 32'd0);

    // Grant 2 is held for 3 cycles while requests change to 0x01, then the next grant is 0.
    output_ready = 1'b0; input_data = 8'h04;
    push_rr(3'd2, 8'h04); push_rr(3'd0, 8'h01);
    step();
    input_data = 8'h01;
    repeat (3) begin
      step();
      chk("hold_valid", {31'd0, rr_valid}, 32'd1);
      chk("hold_data", {29'd0, rr_data}, 32'd2);
      chk("hold_onehot", {24'd0, rr_oh}, 32'h04);
    end
    output_ready = 1'b1;
    step();
    chk("after_hold_data", {29'd0, rr_data}, 32'd0);
    input_data = 8'h00;
    step();
    chk("after_hold_idle", {31'd0, rr_valid}, 32'd0);

    // Reset in the middle of grant 7 discards it, and the next arbitration starts at ptr 0.
    output_ready = 1'b0; input_data = 8'h80;
    push_rr(3'd7, 8'h80);
    step();
    chk("pre_rst_data", {29'd0, rr_data}, 32'd7);
    RST = 1'b1; input_data = 8'hFF;
    step();
    chk("mid_rst_valid", {31'd0, rr_valid}, 32'd0);
    chk("mid_rst_onehot", {24'd0, rr_oh}, 32'd0);
    chk("mid_rst_data", {29'd0, rr_data}, 32'd0);
    q_rr.delete();
    RST = 1'b0; output_ready = 1'b1;
    push_rr(3'd0, 8'h01); push_rr(3'd1, 8'h02); push_rr(3'd2, 8'h04); push_rr(3'd3, 8'h08);
    push_rr(3'd4, 8'h10); push_rr(3'd5, 8'h20); push_rr(3'd6, 8'h40); push_rr(3'd7, 8'h80);
    step();
    chk("post_rst_first", {29'd0, rr_data}, 32'd0);
    repeat (7) step();
    input_data = 8'h00;
    step();
    chk("rot_drain_valid", {31'd0, rr_valid}, 32'd0);

    // Fixed priority: requests 0x26 held always grant 5.
    mon_rr_en = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    mon_fx_en = 1'b1;
    output_ready = 1'b1; input_data = 8'h26;
    repeat (4) push_fx(3'd5, 8'h20);
    repeat (4) begin
      step();
      chk("fx_valid", {31'd0, fx_valid}, 32'd1);
    end
    input_data = 8'h00;
    step();
    chk("fx_drain_valid", {31'd0, fx_valid}, 32'd0);

    step();
    chk("rr_queue_empty", q_rr.size(), 32'd0);
    chk("fx_queue_empty", q_fx.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_priority_arbiter.md
RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

Interface
REQ-001 SHALL have parameter OUTPUT_WIDTH, default 3: width of the granted index.
REQ-002 SHALL have parameter INPUT_WIDTH, default 1<<OUTPUT_WIDTH: number of request lines; legal range 2..(1<<OUTPUT_WIDTH), non-power-of-two allowed.
REQ-003 SHALL have parameter ROUND_ROBIN, default 1: 1 = rotating priority, 0 = fixed priority (highest set index wins).
REQ-004 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port input_data  input  INPUT_WIDTH  request vector, bit i = requester i.
REQ-007 SHALL have port output_ready  input  1  downstream accepts the current grant.
REQ-008 SHALL have port output_valid  output  1  a grant is presented.
REQ-009 SHALL have port output_data  output  OUTPUT_WIDTH  binary index of the granted requester.
REQ-010 SHALL have port output_onehot  output  INPUT_WIDTH  one-hot grant; all-zero when output_valid=0.

Function
REQ-011 SHALL implement two states: IDLE (output_valid=0) and GRANT (output_valid=1); all outputs registered.
REQ-012 SHALL, in IDLE with input_data!=0, register the winner and enter GRANT; the grant is visible one cycle after the sampling edge.
REQ-013 SHALL, in IDLE with input_data==0, remain in IDLE with outputs unchanged.
REQ-014 SHALL, in GRANT with output_ready=0, hold output_data, output_onehot and the pointer unchanged, regardless of input_data changes, including the granted bit dropping.
REQ-015 SHALL, in GRANT with output_ready=1 (handshake), re-arbitrate on the current input_data in the same cycle: a winner is registered and the block stays in GRANT (back-to-back, no bubble); with no requests it goes to IDLE, output_valid=0, output_onehot=0.
REQ-016 SHALL, with ROUND_ROBIN=1, select the lowest set index >= ptr; if none exists, it SHALL select the lowest set index overall (wrap-around).
REQ-017 SHALL keep the ptr register in the range 0..INPUT_WIDTH-1; on each winner registration ptr becomes winner+1, wrapping INPUT_WIDTH-1 -> 0.
REQ-018 SHALL, with ROUND_ROBIN=0, select the highest set index and ignore ptr; ptr still updates per REQ-017 but does not affect selection.
REQ-019 SHALL guarantee each continuously asserted request a grant within INPUT_WIDTH handshakes when ROUND_ROBIN=1.
REQ-020 SHALL keep output_data at its last value when returning to IDLE; output_data is don't-care to consumers when output_valid=0.
REQ-021 SHALL ignore input_data bits at index >= INPUT_WIDTH (none exist); output_data SHALL never exceed INPUT_WIDTH-1.

Reset
REQ-022 SHALL, on RST=1 at a rising edge, force state=IDLE, output_valid=0, output_data=0, output_onehot=0, ptr=0, overriding output_ready and input_data.
REQ-023 SHALL, on RST asserted mid-GRANT, discard the pending grant with no handshake; the first post-reset arbitration starts from ptr=0.

Verification (INPUT_WIDTH=8, OUTPUT_WIDTH=3)
REQ-024 SHALL cover: reset, input_data=8'h00 for 5 cycles -> output_valid stays 0, output_onehot=8'h00.
REQ-025 SHALL cover: ROUND_ROBIN=1, ptr=0, input_data=8'h84 held, output_ready=1 -> output_data sequence 2,7,2,7, output_valid continuously 1 starting one cycle after the first request.
REQ-026 SHALL cover: grant 2 held with output_ready=0 for 3 cycles while input_data changes to 8'h01 -> output_data=2 and output_onehot=8'h04 throughout; after ready=1 the next grant is 0.
REQ-027 SHALL cover: after grant 7 (ptr wraps to 0), input_data=8'h81 -> grants 0 then 7.
REQ-028 SHALL cover: ROUND_ROBIN=0, input_data=8'h26 held, output_ready=1 -> output_data=5 on every cycle.
REQ-029 SHALL cover: GRANT with output_data=7, then RST=1 for 1 cycle -> next cycle output_valid=0, output_onehot=8'h00; then input_data=8'hFF -> first grant 0.
